// File: rtl/mc_control_unit_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath:
// instruction fields and branch flag in, strobes and selects out.
interface mc_control_unit_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Flag;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUControl;
  logic [1:0] BorN;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Flag,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUControl, BorN,
           InstrDone, State
  );

  modport slave (
    output Opcode, Funct, Flag,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUControl, BorN,
           InstrDone, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main control: Moore FSM decoding the IR fields into
// datapath strobes, mux selects and ALU/branch-compare controls.
module mc_control_unit (
  input  logic                 clk,
  input  logic                 Reset,
  mc_control_unit_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_BLE   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Returns {legal, ALUControl}; unknown functs fall back to ADD but are illegal.
  function automatic logic [3:0] f_funct_dec(input logic [5:0] fn);
    case (fn)
      6'b100000: f_funct_dec = {1'b1, 3'b010};
      6'b100010: f_funct_dec = {1'b1, 3'b011};
      6'b100100: f_funct_dec = {1'b1, 3'b101};
      6'b100101: f_funct_dec = {1'b1, 3'b100};
      6'b100110: f_funct_dec = {1'b1, 3'b110};
      6'b101010: f_funct_dec = {1'b1, 3'b111};
      6'b000001: f_funct_dec = {1'b1, 3'b000};
      6'b000010: f_funct_dec = {1'b1, 3'b001};
      default:   f_funct_dec = {1'b0, 3'b010};
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_funct_dec;

  assign w_funct_dec = f_funct_dec(bus.Funct);

  always_ff @(posedge clk) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:                       w_next = S_EXECUTE;
          OP_LW, OP_SW:                   w_next = S_MEMADR;
          OP_BEQ, OP_BNE, OP_BLT, OP_BLE: w_next = S_BRANCH;
          OP_ADDI:                        w_next = S_ADDIEX;
          OP_J:                           w_next = S_JUMP;
          default:                        w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (bus.Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Output decode; Reset overrides everything so an aborted instruction writes nothing.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.PCSource   = 2'b00;
    bus.ALUControl = 3'b000;
    bus.BorN       = 2'b00;
    bus.InstrDone  = 1'b0;
    bus.State      = 4'd0;
    if (!Reset) begin
      bus.State = r_state;
      case (r_state)
        S_FETCH: begin
          bus.MemRead    = 1'b1;
          bus.IRWrite    = 1'b1;
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = 3'b010;
          bus.PCWrite    = 1'b1;
        end
        S_DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.ALUControl = 3'b010;
          bus.InstrDone  = (w_next == S_FETCH);
        end
        S_MEMADR: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = 2'b10;
          bus.ALUControl = 3'b010;
        end
        S_MEMREAD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.MemtoReg  = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_MEMWRITE: begin
          bus.MemWrite  = 1'b1;
          bus.IorD      = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_EXECUTE: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = w_funct_dec[2:0];
        end
        S_ALUWB: begin
          bus.RegDst    = 1'b1;
          bus.RegWrite  = w_funct_dec[3];
          bus.InstrDone = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA   = 1'b1;
          bus.BorN      = bus.Opcode[1:0];
          bus.PCSource  = 2'b01;
          bus.PCWrite   = bus.Flag;
          bus.InstrDone = 1'b1;
        end
        S_ADDIEX: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUSrcB    = 2'b10;
          bus.ALUControl = 3'b010;
        end
        S_ADDIWB: begin
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
        end
        S_JUMP: begin
          bus.PCSource  = 2'b10;
          bus.PCWrite   = 1'b1;
          bus.InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed cycle-by-cycle vectors for mc_control_unit plus a bounded
// instruction-length check.
module tb_mc_control_unit;

  logic clk;
  logic Reset;
  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        flag;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //  ALUSrcB,PCSource,ALUControl,BorN,InstrDone,State}
  function automatic logic [22:0] mk(
    input logic pcw, iord, mr, mw, irw, rd, m2r, rw, asa,
    input logic [1:0] asb, input logic [1:0] pcs, input logic [2:0] alu,
    input logic [1:0] born, input logic done, input logic [3:0] st);
    mk = {pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, born, done, st};
  endfunction

  function automatic logic [22:0] actual();
    actual = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
              bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
              bus.PCSource, bus.ALUControl, bus.BorN, bus.InstrDone, bus.State};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic flag, input logic [22:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.flag = flag; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  logic [22:0] ZERO, FET, DEC, DEC_DONE, MADR, MRD, MWB, MWR, ADDX, ADDW, JMP;

  initial begin
    ZERO     = '0;
    FET      = mk(1,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 2'b00, 0, 4'd0);
    DEC      = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 2'b00, 0, 4'd1);
    DEC_DONE = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 2'b00, 1, 4'd1);
    MADR     = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 2'b00, 0, 4'd2);
    MRD      = mk(0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 4'd3);
    MWB      = mk(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd4);
    MWR      = mk(0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd5);
    ADDX     = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 2'b00, 0, 4'd9);
    ADDW     = mk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd10);
    JMP      = mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 2'b00, 1, 4'd11);

    // Reset held three cycles: everything forced low.
    for (int i = 0; i < 3; i++) add(1, 6'b100011, 6'd0, 0, ZERO);
    // lw
    add(0, 6'b100011, 6'd0, 0, FET);
    add(0, 6'b100011, 6'd0, 0, DEC);
    add(0, 6'b100011, 6'd0, 0, MADR);
    add(0, 6'b100011, 6'd0, 0, MRD);
    add(0, 6'b100011, 6'd0, 0, MWB);
    // sw
    add(0, 6'b101011, 6'd0, 0, FET);
    add(0, 6'b101011, 6'd0, 0, DEC);
    add(0, 6'b101011, 6'd0, 0, MADR);
    add(0, 6'b101011, 6'd0, 0, MWR);
    // R-type sub
    add(0, 6'b000000, 6'b100010, 0, FET);
    add(0, 6'b000000, 6'b100010, 0, DEC);
    add(0, 6'b000000, 6'b100010, 0, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b011, 2'b00, 0, 4'd6));
    add(0, 6'b000000, 6'b100010, 0, mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd7));
    // R-type or
    add(0, 6'b000000, 6'b100101, 0, FET);
    add(0, 6'b000000, 6'b100101, 0, DEC);
    add(0, 6'b000000, 6'b100101, 0, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b100, 2'b00, 0, 4'd6));
    add(0, 6'b000000, 6'b100101, 0, mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd7));
    // R-type illegal funct: ADD in EXECUTE, no register write
    add(0, 6'b000000, 6'b111111, 0, FET);
    add(0, 6'b000000, 6'b111111, 0, DEC);
    add(0, 6'b000000, 6'b111111, 0, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 2'b00, 0, 4'd6));
    add(0, 6'b000000, 6'b111111, 0, mk(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 4'd7));
    // ble taken / not taken
    add(0, 6'b000111, 6'd0, 1, FET);
    add(0, 6'b000111, 6'd0, 1, DEC);
    add(0, 6'b000111, 6'd0, 1, mk(1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b000, 2'b11, 1, 4'd8));
    add(0, 6'b000111, 6'd0, 0, FET);
    add(0, 6'b000111, 6'd0, 0, DEC);
    add(0, 6'b000111, 6'd0, 0, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b000, 2'b11, 1, 4'd8));
    // bne taken
    add(0, 6'b000101, 6'd0, 1, FET);
    add(0, 6'b000101, 6'd0, 1, DEC);
    add(0, 6'b000101, 6'd0, 1, mk(1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b000, 2'b01, 1, 4'd8));
    // addi
    add(0, 6'b001000, 6'd0, 0, FET);
    add(0, 6'b001000, 6'd0, 0, DEC);
    add(0, 6'b001000, 6'd0, 0, ADDX);
    add(0, 6'b001000, 6'd0, 0, ADDW);
    // j
    add(0, 6'b000010, 6'd0, 0, FET);
    add(0, 6'b000010, 6'd0, 0, DEC);
    add(0, 6'b000010, 6'd0, 0, JMP);
    // unknown opcode: done in DECODE, straight back to FETCH
    add(0, 6'b111111, 6'd0, 0, FET);
    add(0, 6'b111111, 6'd0, 0, DEC_DONE);
    // sw aborted by Reset in MEMWRITE
    add(0, 6'b101011, 6'd0, 0, FET);
    add(0, 6'b101011, 6'd0, 0, DEC);
    add(0, 6'b101011, 6'd0, 0, MADR);
    add(1, 6'b101011, 6'd0, 0, ZERO);
    add(0, 6'b101011, 6'd0, 0, FET);

    for (int i = 0; i < vecs.size(); i++) begin
      Reset      = vecs[i].rst;
      bus.Opcode = vecs[i].op;
      bus.Funct  = vecs[i].fn;
      bus.Flag   = vecs[i].flag;
      #2;
      check($sformatf("vec%0d", i), {9'd0, actual()}, {9'd0, vecs[i].exp});
      @(posedge clk);
      #1;
    end

    // lw from a clean FETCH: exactly 5 cycles and a single InstrDone pulse.
    begin
      int cycles, dones;
      Reset = 1'b1; bus.Opcode = 6'b100011; bus.Funct = 6'd0; bus.Flag = 1'b0;
      @(posedge clk); #1;
      Reset = 1'b0;
      cycles = 0; dones = 0;
      do begin
        #2;
        cycles++;
        if (bus.InstrDone) dones++;
        @(posedge clk); #1;
      end while (bus.State != 4'd0 && cycles < 20);
      check("lw_cycles", cycles, 5);
      check("lw_done_pulses", dones, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS main control FSM that decodes the instruction register fields and drives every datapath strobe, mux select and the ALU's `ALUControl`/`BorN` inputs. It consumes the ALU's branch `Flag` to decide conditional PC writes. It sits between the instruction register and the datapath, which holds the PC, memory, register file and ALU.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `Reset` in 1: reset, synchronous, active-high.
- `Opcode` in 6: IR[31:26]; stable from the cycle after FETCH until the next FETCH.
- `Funct` in 6: IR[5:0].
- `Flag` in 1: ALU branch-compare result, combinational, valid in the same cycle.
- `PCWrite` out 1: PC load enable.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1 / `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: IR load enable.
- `RegDst` out 1: write register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write data select; 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input select; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B input select; 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `PCSource` out 2: PC source select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUControl` out 3: 000 MOV(B), 001 NOT B, 010 ADD, 011 SUB (B−A), 100 OR, 101 AND, 110 XOR, 111 SET (A>=B).
- `BorN` out 2: branch compare select; 00 EQ, 01 NE, 10 LT, 11 LE.
- `InstrDone` out 1: one-cycle pulse in the final state of each instruction.
- `State` out 4: current state, for debug.

## Operation
- Moore FSM. All outputs decode combinationally from the registered state, except `PCWrite` in BRANCH, which is `Flag`.
- Any output not listed for a state is 0. `ALUControl` and `BorN` default to 000 and 00.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 go to FETCH on the next edge.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUControl=010, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcB=11, ALUControl=010 (branch target computed into ALUOut). Next state by `Opcode`:
  - 000000 (R-type) → EXECUTE
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 / 000101 / 000110 / 000111 (beq/bne/blt/ble) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH with `InstrDone`=1 and no writes.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemRead=1, IorD=1. Next state MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWRITE: MemWrite=1, IorD=1, InstrDone=1. Next state FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. `ALUControl` decodes from `Funct`:
  - 100000 → 010, 100010 → 011, 100100 → 101, 100101 → 100
  - 100110 → 110, 101010 → 111, 000001 → 000, 000010 → 001
  - any other funct → 010, and the instruction is flagged illegal.
- ALUWB: RegDst=1, RegWrite=1 only for a legal funct, InstrDone=1. Next state FETCH.
- BRANCH: ALUSrcA=1, BorN=Opcode[1:0], PCSource=01, PCWrite=Flag, InstrDone=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state ADDIWB.
- ADDIWB: RegWrite=1, InstrDone=1. Next state FETCH.
- JUMP: PCSource=10, PCWrite=1, InstrDone=1. Next state FETCH.

## Timing
- Reset is synchronous. With `Reset`=1 at an edge, state becomes FETCH.
- While `Reset` is high, every output is forced to 0 (ALUControl 000, BorN 00, State 0), overriding the FETCH decode.
- On the first edge after `Reset` falls, FETCH is active with its strobes asserted.
- Reset asserted mid-instruction aborts it; no further write strobe is issued for that instruction.
- Cycles per instruction, counted from FETCH through the `InstrDone` state inclusive:
  - lw 5
  - sw, R-type, addi 4
  - branch, j 3
  - unknown opcode 2
- `Flag` must settle within the BRANCH cycle; the PC is written on the BRANCH→FETCH edge only if `Flag`=1.
- `InstrDone` is high for exactly one cycle per instruction and never during reset.

## Test plan
- Reset held for 3 cycles, then released → all outputs 0 during reset; next cycle State=0 with MemRead=IRWrite=PCWrite=1 and ALUSrcB=01.
- lw (Opcode 100011) → State sequence 0,1,2,3,4,0; MemWB cycle has RegWrite=1, MemtoReg=1; InstrDone pulses once.
- R-type sub (Funct 100010) → EXECUTE ALUControl=011; ALUWB RegDst=1, RegWrite=1. Funct 111111 → ALUWB with RegWrite=0.
- ble (Opcode 000111): Flag=1 → BorN=11, PCWrite=1, PCSource=01. Repeat with Flag=0 → PCWrite=0. Both take 3 cycles.
- Opcode 111111 → DECODE then FETCH, with zero write strobes and InstrDone=1 in DECODE.
- Reset asserted during MEMWRITE of sw → MemWrite=0 that cycle; State=0 after release.
